// File: rtl/time_ctrl_unit.sv
// Stopwatch/watch controller: base tick divider, stopwatch run/stop/clear FSM,
// watch time-set FSM with blink, and routing of debounced button pulses.
module time_ctrl_unit #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned TICK_HZ  = 100,
    parameter int unsigned BLINK_HZ = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_mode,
    input  logic       i_btn_run,
    input  logic       i_btn_clr,
    input  logic       i_btn_sel,
    input  logic       i_btn_inc,
    output logic       o_mode,
    output logic       o_sw_tick,
    output logic       o_sw_clear,
    output logic       o_wt_tick,
    output logic [2:0] o_wt_inc,
    output logic [1:0] o_set_field,
    output logic       o_blink
);

    localparam int unsigned DIV  = CLK_FREQ / TICK_HZ;
    localparam int unsigned BDIV = CLK_FREQ / (2 * BLINK_HZ);
    localparam int unsigned DW   = $clog2(DIV);
    localparam int unsigned BW   = $clog2(BDIV + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [BW-1:0] BDIV_LAST = BW'(BDIV - 1);

    typedef enum logic [1:0] {
        SwStop  = 2'd0,
        SwRun   = 2'd1,
        SwClear = 2'd2
    } sw_state_e;

    // Encoding doubles as the o_set_field value.
    typedef enum logic [1:0] {
        WtNormal  = 2'd0,
        WtSetHour = 2'd1,
        WtSetMin  = 2'd2,
        WtSetSec  = 2'd3
    } wt_state_e;

    logic [DW-1:0] div_cnt;
    logic          base_tick;
    logic          mode_q;
    sw_state_e     sw_state;
    wt_state_e     wt_state;
    wt_state_e     wt_next_sel;
    logic [BW-1:0] blink_cnt;
    logic          blink_q;
    logic [2:0]    inc_q;
    logic          sw_run, sw_clr, wt_sel, wt_inc;

    // A mode press swallows every other button in the same cycle.
    always_comb begin
        sw_run      = !i_btn_mode && !mode_q && i_btn_run;
        sw_clr      = !i_btn_mode && !mode_q && i_btn_clr && !i_btn_run;
        wt_sel      = !i_btn_mode && mode_q && i_btn_sel;
        wt_inc      = !i_btn_mode && mode_q && i_btn_inc && !i_btn_sel;
        wt_next_sel = wt_state_e'(wt_state + 2'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            base_tick <= 1'b0;
        end else begin
            base_tick <= (div_cnt == DIV_LAST);
            div_cnt   <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 1'b0;
        end else if (i_btn_mode) begin
            mode_q <= !mode_q;
        end
    end

    // Stopwatch state survives mode changes so it keeps running in the background.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_state <= SwStop;
        end else begin
            unique case (sw_state)
                SwStop: begin
                    if (sw_run) begin
                        sw_state <= SwRun;
                    end else if (sw_clr) begin
                        sw_state <= SwClear;
                    end
                end
                SwRun: begin
                    if (sw_run) begin
                        sw_state <= SwStop;
                    end
                end
                SwClear: sw_state <= SwStop;
                default: sw_state <= SwStop;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wt_state  <= WtNormal;
            blink_cnt <= '0;
            blink_q   <= 1'b0;
            inc_q     <= 3'b000;
        end else begin
            inc_q <= 3'b000;
            if (i_btn_mode) begin
                wt_state  <= WtNormal;
                blink_cnt <= '0;
                blink_q   <= 1'b0;
            end else if (wt_sel) begin
                wt_state  <= wt_next_sel;
                blink_cnt <= '0;
                blink_q   <= (wt_next_sel != WtNormal);
            end else if (wt_state != WtNormal) begin
                if (blink_cnt == BDIV_LAST) begin
                    blink_cnt <= '0;
                    blink_q   <= !blink_q;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
                if (wt_inc) begin
                    unique case (wt_state)
                        WtSetHour: inc_q <= 3'b100;
                        WtSetMin:  inc_q <= 3'b010;
                        WtSetSec:  inc_q <= 3'b001;
                        default:   inc_q <= 3'b000;
                    endcase
                end
            end
        end
    end

    always_comb begin
        o_mode      = mode_q;
        o_sw_tick   = base_tick & (sw_state == SwRun);
        o_wt_tick   = base_tick & (wt_state == WtNormal);
        o_sw_clear  = (sw_state == SwClear);
        o_wt_inc    = inc_q;
        o_set_field = wt_state;
        o_blink     = blink_q;
    end

endmodule

// File: doc/time_ctrl_unit.md
Name: time_ctrl_unit

Overview:
- Central controller for the stopwatch/watch counter chains on Basys3.
- Generates the base time tick from the system clock and gates it per mode.
- Runs the stopwatch run/stop/clear FSM and the watch time-set FSM; routes debounced button pulses to whichever function is active.
- Emits per-field increment pulses and a blink enable for the display.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- TICK_HZ, 100, base tick rate in Hz. DIV = CLK_FREQ/TICK_HZ must be an integer ≥ 2.
- BLINK_HZ, 2, blink rate in Hz while setting. BDIV = CLK_FREQ/(2*BLINK_HZ) clocks per toggle.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_btn_mode  in  1  one-cycle pulse; toggles stopwatch/watch mode
- i_btn_run  in  1  one-cycle pulse; stopwatch run/stop toggle
- i_btn_clr  in  1  one-cycle pulse; stopwatch clear
- i_btn_sel  in  1  one-cycle pulse; watch set-field select
- i_btn_inc  in  1  one-cycle pulse; watch field increment
- o_mode  out  1  0 = stopwatch, 1 = watch
- o_sw_tick  out  1  gated tick to the stopwatch counter chain
- o_sw_clear  out  1  one-cycle synchronous clear to the stopwatch counters
- o_wt_tick  out  1  gated tick to the watch counter chain
- o_wt_inc  out  3  one-hot increment pulse: [2] hour, [1] min, [0] sec
- o_set_field  out  2  0 none, 1 hour, 2 min, 3 sec
- o_blink  out  1  display blink enable; 0 when not setting

Behaviour:
- Reset values: all outputs 0; divider counters 0; SW FSM in STOP; WT FSM in NORMAL; mode 0.
- Base tick:
  - Free-running divider counts 0..DIV-1 and wraps.
  - The registered base_tick is high for exactly one cycle per wrap, in the cycle after the counter reaches DIV-1.
  - The divider is cleared only by rst; run/stop and mode changes never reset its phase.
- o_sw_tick = base_tick AND (SW state == RUN). o_wt_tick = base_tick AND (WT state == NORMAL). No other logic on these paths.
- Button routing:
  - i_btn_mode is always honoured.
  - run/clr reach the SW FSM only when o_mode = 0.
  - sel/inc reach the WT FSM only when o_mode = 1.
  - Buttons routed to the inactive function are dropped, not queued.
- Same-cycle priority:
  - If i_btn_mode is high, the mode toggles and all other buttons that cycle are ignored.
  - Within SW, run beats clr.
  - Within WT, sel beats inc.
- SW FSM (states STOP, RUN, CLEAR):
  - STOP + run → RUN.
  - STOP + clr → CLEAR.
  - RUN + run → STOP.
  - RUN + clr → ignored.
  - CLEAR → STOP unconditionally after 1 cycle; o_sw_clear = 1 only while in CLEAR.
  - The SW FSM keeps its state across mode changes, so the stopwatch runs in the background while in watch mode.
- WT FSM (states NORMAL, SET_HOUR, SET_MIN, SET_SEC):
  - sel advances NORMAL → SET_HOUR → SET_MIN → SET_SEC → NORMAL.
  - o_set_field encodes the current state (0/1/2/3).
  - inc in a SET_x state produces the matching o_wt_inc bit high for exactly one cycle, in the cycle after the pulse (registered).
  - inc in NORMAL is ignored.
  - Mode toggle to stopwatch forces the WT FSM to NORMAL in the same transition, so the watch resumes ticking.
- Latency: a button pulse in cycle N produces the state or output change visible in cycle N+1.
- Blink:
  - While in any SET_x state, o_blink toggles every BDIV cycles.
  - On entry to each SET_x state, the blink counter resets and o_blink = 1.
  - In NORMAL, o_blink = 0 and the counter is held at 0.
- Ticks lost while in SET_x are dropped; they are not accumulated.
- Reset mid-operation: asynchronous return to the reset values above, including clearing any pending inc pulse.

Test Plan:
- Setup: CLK_FREQ=1000, TICK_HZ=100, BLINK_HZ=50 → DIV=10, BDIV=10.
- Release rst, idle 40 cycles → o_sw_tick stays 0; o_wt_tick pulses every 10 cycles (4 pulses), each 1 cycle wide.
- i_btn_run, wait 30 cycles, i_btn_run → exactly 3 o_sw_tick pulses, then none. Then i_btn_clr → o_sw_clear high for exactly 1 cycle, one cycle after the pulse; SW returns to STOP.
- i_btn_run and i_btn_clr in the same cycle from STOP → RUN entered, no o_sw_clear. i_btn_clr while RUN → ignored, ticks continue.
- i_btn_mode, then i_btn_sel x2 → o_set_field = 2 and o_wt_tick silent. i_btn_inc → o_wt_inc = 3'b010 for 1 cycle. o_blink = 1 on SET_MIN entry, toggles every 10 cycles.
- In SET_SEC, i_btn_mode → o_mode = 0, o_set_field = 0, o_blink = 0, o_wt_tick resumes. Stopwatch left in RUN before the mode switch still emits o_sw_tick in watch mode.
- Assert rst mid-SET_HOUR with an inc pulse pending → all outputs 0 immediately (asynchronous), no o_wt_inc pulse after release.
